// File: rtl/alu_pipe.sv
// Pipelined ALU with registered result and flag outputs and a valid/ready handshake on each side.
// Single-cycle ops complete on acceptance; MUL runs an iterative shift-add sequence lasting WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] source_1,
  input  logic [WIDTH-1:0] source_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       nzcv,
  output logic             fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // The producer holds its payload stable while valid=1 and ready=0.
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             mul_flags;
  logic [WIDTH-1:0] acc_next;

  logic             accept;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   asr_w;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign fsm_state = state;
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept    = in_valid && in_ready;

  // Every add/subtract variant is mapped onto one adder: x + y + cin.
  always_comb begin
    add_x   = source_1;
    add_y   = source_2;
    add_cin = 1'b0;
    case (alu_op)
      5'd2, 5'd10: begin add_y = ~source_2; add_cin = 1'b1; end
      5'd3:        begin add_x = source_2; add_y = ~source_1; add_cin = 1'b1; end
      5'd5:        add_cin = nzcv[1];
      5'd6:        begin add_y = ~source_2; add_cin = nzcv[1]; end
      5'd7:        begin add_x = source_2; add_y = ~source_1; add_cin = nzcv[1]; end
      default:     ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

  // One guard bit beyond the data catches the last bit shifted out (0 for a zero shift).
  assign shamt = source_2[SHW-1:0];
  assign lsl_w = {1'b0, source_1} << shamt;
  assign lsr_w = {source_1, 1'b0} >> shamt;
  assign asr_w = $signed({source_1, 1'b0}) >>> shamt;

  always_comb begin
    res   = source_2;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_op)
      5'd0, 5'd8:  res = source_1 & source_2;
      5'd1, 5'd9:  res = source_1 ^ source_2;
      5'd12:       res = source_1 | source_2;
      5'd14:       res = source_1 & ~source_2;
      5'd15:       res = ~source_2;
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      5'd16: begin res = lsl_w[WIDTH-1:0]; res_c = lsl_w[WIDTH]; end
      5'd17: begin res = lsr_w[WIDTH:1];   res_c = lsr_w[0];     end
      5'd18: begin res = asr_w[WIDTH:1];   res_c = asr_w[0];     end
      default:     res = source_2;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_flags <= 1'b0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      nzcv      <= 4'b0000;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_op == 5'd19) begin
              state     <= MUL;
              count     <= '0;
              acc       <= '0;
              mcand     <= source_1;
              mplier    <= source_2;
              mul_flags <= set_flags;
            end else begin
              alu_out   <= res;
              out_valid <= 1'b1;
              if (set_flags) nzcv <= {res[WIDTH-1], res == '0, res_c, res_v};
            end
          end
        end
        MUL: begin
          // The final step's partial sum goes straight to the output register.
          if (count == CNT_LAST) begin
            state     <= IDLE;
            count     <= '0;
            alu_out   <= acc_next;
            out_valid <= 1'b1;
            if (mul_flags) nzcv <= {acc_next[WIDTH-1], acc_next == '0, 2'b00};
          end else begin
            count  <= count + CW'(1);
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width; legal values are 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  as its reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  indicating an operation is offered.
REQ-006 The block SHALL have port in_ready  output  1  indicating the block accepts the offered operation this cycle.
REQ-007 The block SHALL have port alu_op  input  5  selecting the operation.
REQ-008 The block SHALL have port set_flags  input  1  requesting a flag-register update for this operation.
REQ-009 The block SHALL have port source_1  input  WIDTH  as operand A.
REQ-010 The block SHALL have port source_2  input  WIDTH  as operand B.
REQ-011 The block SHALL have port out_valid  output  1  indicating alu_out holds a result.
REQ-012 The block SHALL have port out_ready  input  1  indicating the consumer takes the result.
REQ-013 The block SHALL have port alu_out  output  WIDTH  carrying the registered result.
REQ-014 The block SHALL have port nzcv  output  4  carrying the registered flag register, with N in bit 3, Z in bit 2, C in bit 1 and V in bit 0.

Function
REQ-015 Ops 0-15 SHALL behave as follows, where c is nzcv[1]:
- 0,8: AND.
- 1,9: XOR.
- 2,10: A-B.
- 3: B-A.
- 4,11: A+B.
- 5: A+B+c.
- 6: A+~B+c.
- 7: B+~A+c.
- 12: OR.
- 13: B.
- 14: A&~B.
- 15: ~B.
REQ-016 Ops 16, 17 and 18 SHALL be LSL, LSR and ASR of A by B[SHW-1:0]; op 19 SHALL be MUL, giving the low WIDTH bits of A*B; ops 20-31 SHALL be treated as op 13.
REQ-017 Arithmetic ops SHALL compute C as the carry out of the WIDTH-bit sum, including the internal +1 for subtraction (C=1 means no borrow), and V as signed overflow of that sum.
REQ-018 Logical ops, op 13, op 15 and MUL SHALL produce C=0 and V=0.
REQ-019 Shifts SHALL produce V=0 and C equal to the last bit shifted out; a shift amount of 0 SHALL give C=0 and an unchanged A.
REQ-020 Every op SHALL produce N = result[WIDTH-1] and Z = (result == 0).
REQ-021 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !rst; an operation is accepted when in_valid && in_ready.
REQ-022 Ops other than 19 SHALL have latency 1: accepted at edge t, with alu_out and out_valid=1 visible after edge t, which allows back-to-back issue.
REQ-023 MUL SHALL use an iterative shift-add FSM with states IDLE and MUL and a counter of WIDTH iterations; the result SHALL load after WIDTH cycles in MUL, and the FSM SHALL then return to IDLE with in_ready=0 throughout MUL.
REQ-024 The result SHALL be consumed when out_valid && out_ready; out_valid SHALL fall unless a new result loads on the same edge.
REQ-025 alu_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 nzcv SHALL update on the same edge the result loads, and only if set_flags was 1 at acceptance; otherwise it SHALL hold.
REQ-027 Ops 5, 6 and 7 SHALL use the nzcv[1] value present at their acceptance edge, which includes a C just written by the immediately preceding op.
REQ-028 Operands, op and set_flags SHALL be captured at acceptance; later input changes SHALL NOT affect an in-flight MUL.

Reset
REQ-029 While rst=1, the block SHALL force out_valid=0, alu_out=0, nzcv=4'b0000, state=IDLE, counter=0 and in_ready=0.
REQ-030 rst SHALL take priority over every other event, including mid-MUL, discarding the pending operation and producing no result.
REQ-031 The first acceptance SHALL be possible in the first cycle after rst falls.

Verification
REQ-032 With WIDTH=32, op 2, A=5, B=5, set_flags=1 -> next cycle alu_out=0, nzcv=4'b0110.
REQ-033 With WIDTH=32, op 4, A=0x7FFFFFFF, B=1, set_flags=1, then op 5, A=0, B=0 back-to-back -> first result 0x80000000 with nzcv=1001; second result 0 with nzcv=0100.
REQ-034 With WIDTH=8, op 19, A=0x0D, B=0x0B -> in_ready=0 for 8 cycles, then alu_out=0x8F and nzcv=1000.
REQ-035 With WIDTH=32, op 18, A=0x80000001, B=1 -> alu_out=0xC0000000, C=1.
REQ-036 With out_ready held low for 3 cycles after a result -> alu_out stable, in_ready=0, and a new op accepted in the cycle out_ready rises.
REQ-037 With rst asserted on the 4th cycle of a MUL -> no out_valid, nzcv=0, and in_ready=1 in the cycle after rst falls.
